serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract controller that time-shares one external 1-bit full adder (A, B, C in; Y[1:0] = {carry, sum} out) across N-bit operands. It latches the operands on a start request and presents one bit column per clock to the full adder, LSB first. It captures the adder's sum and carry back each cycle and reports an N-bit result with carry-out and signed overflow. The block sits between a requesting datapath and the shared full-adder instance; it sequences the adder and does not compute any arithmetic itself.

## Interface
- N, default 8, operand/result width in bits (N ≥ 2)
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on rising clk edge
- sub  input  1  0 = add, 1 = subtract (a − b); latched with start
- cin  input  1  carry-in for add; ignored when sub = 1
- a  input  N  operand A; latched with start
- b  input  N  operand B; latched with start
- fa_a  output  1  full-adder input A (current bit of A)
- fa_b  output  1  full-adder input B (current bit of B, inverted if sub)
- fa_c  output  1  full-adder input C (running carry)
- fa_y  input  2  full-adder result: fa_y[1] = carry out, fa_y[0] = sum
- busy  output  1  high while columns are being processed
- done  output  1  one-cycle completion pulse
- sum  output  N  result; holds the last completed value
- cout  output  1  carry out of MSB of the last result (for subtract, 1 = no borrow)
- ovf  output  1  signed overflow of the last result (carry into MSB XOR carry out of MSB)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start = 1 is accepted. Latch a_sh ← a and b_sh ← (sub ? ~b : b). Load carry ← (sub ? 1 : cin) and bit counter ← 0. Go to RUN.
- RUN: fa_a = a_sh[0], fa_b = b_sh[0], fa_c = carry. These are driven combinationally from registers only, with no path from fa_y.
- Each RUN edge:
  - res_sh shifts right with fa_y[0] entering at the MSB.
  - a_sh and b_sh shift right.
  - carry ← fa_y[1].
  - Counter increments.
  - On the edge where counter = N−2, record msb_cin ← fa_y[1].
- The edge with counter = N−1 is the last column:
  - sum ← {fa_y[0], res_sh[N−1:1]}.
  - cout ← fa_y[1].
  - ovf ← msb_cin XOR fa_y[1].
  - Go to DONE.
- DONE: done = 1 for exactly this cycle. start = 1 is accepted as in IDLE and goes to RUN; otherwise go to IDLE.
- start in RUN is ignored: operands are not relatched and there is no queueing.
- busy = 1 only in RUN. done = 1 only in DONE.
- fa_a, fa_b and fa_c are 0 in IDLE and DONE.
- Result registers (sum, cout, ovf) change only on the last-column edge. Their contents are stable throughout RUN.
- Arithmetic is modulo 2^N. The counter is ceil(log2 N) bits and never wraps inside an operation.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, fa_a/fa_b/fa_c 0, all internal registers 0.
- rst_n low at any time, including mid-RUN: abort immediately. No done pulse; the previous result is cleared to 0.
- Latency: start sampled at edge E0, then RUN during cycles E0..E(N). Result and done are visible after edge E(N), and done drops at E(N+1).
- Throughput: with start held high in DONE, one operation per N+1 cycles.
- The external full adder must settle within one clk period; fa_y is sampled only on RUN edges.

## Test plan
- N = 8, add, a = 0x5A, b = 0x33, cin = 0: busy high 8 cycles, then done pulse with sum = 0x8D, cout = 0, ovf = 1.
- Subtract, a = 0x10, b = 0x20: sum = 0xF0, cout = 0, ovf = 0. Also subtract a = 0x80, b = 0x01: sum = 0x7F, cout = 1, ovf = 1.
- Add a = 0xFF, b = 0x00, cin = 1: sum = 0x00, cout = 1, ovf = 0. Check fa_c is 1 in the first RUN cycle.
- Pulse start again with a = 0x01 at RUN cycle 3 of an add 0x0F + 0x01: the second start is ignored. Result 0x10 arrives at the original time, with exactly one done pulse.
- Hold start high continuously (a = 0x01, b = 0x01): done pulses every 9 cycles and sum = 0x02 each time. busy is low for exactly one cycle between operations.
- Assert rst_n low at RUN cycle 5: all outputs 0 immediately, no done pulse, and state is IDLE. A fresh start after release completes normally.

Source files
------------

// File: rtl/serial_add_if.sv
// Handshake and full-adder bundle for serial_add_ctrl.
//   master: requester plus shared full adder (drives start/sub/cin/a/b/fa_y)
//   slave : the controller (drives fa_a/fa_b/fa_c, busy, done, sum, cout, ovf)
interface serial_add_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         fa_a;
    logic         fa_b;
    logic         fa_c;
    logic [1:0]   fa_y;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, cin, a, b, fa_y,
        input  fa_a, fa_b, fa_c, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b, fa_y,
        output fa_a, fa_b, fa_c, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer for one shared external 1-bit full adder.
// Presents one operand column per clock (LSB first), collects {carry, sum}
// from the adder, and reports an N-bit result with carry-out and overflow.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - serial_add_if.slave: start/sub/cin/a/b request, fa_a/fa_b/fa_c
//           to the adder, fa_y from the adder, busy/done/sum/cout/ovf status
module serial_add_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_add_if.slave  bus
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-2:0]  res_sh;   // earlier N-1 sum bits; the last one comes from fa_y
    logic          carry;
    logic          msb_cin;
    logic [CW-1:0] cnt;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    // Shift-in view of the result including the current column's sum bit
    logic [N-1:0]  res_next;
    assign res_next = {bus.fa_y[0], res_sh};

    // Operand and carry registers are all zero outside RUN (operands are fully
    // shifted out and carry is cleared on the last column), so the adder
    // inputs are taken straight from register bits without state gating.
    assign bus.fa_a = a_sh[0];
    assign bus.fa_b = b_sh[0];
    assign bus.fa_c = carry;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

    // Sequencer, datapath shifters and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            msb_cin <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub | bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    res_sh <= res_next[N-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= bus.fa_y[1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(N - 2)) begin
                        msb_cin <= bus.fa_y[1];
                    end
                    if (cnt == CW'(N - 1)) begin
                        sum_q  <= res_next;
                        cout_q <= bus.fa_y[1];
                        ovf_q  <= msb_cin ^ bus.fa_y[1];
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full adder on the bus.
module tb_serial_add_ctrl;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_add_if #(.N(N)) bus ();

    // Shared 1-bit full adder: {carry, sum}
    assign bus.fa_y = {(bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_c) | (bus.fa_b & bus.fa_c),
                       bus.fa_a ^ bus.fa_b ^ bus.fa_c};

    serial_add_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       sub;
        logic       cin;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs [9];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One full operation: latency, busy width, adder inputs and result
    task automatic do_op(input vec_t v, input int idx);
        int lat    = 0;
        int busy_n = 0;
        bit got    = 0;
        @(negedge clk);
        bus.sub   = v.sub;
        bus.cin   = v.cin;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 1) begin
                check($sformatf("v%0d_fa_c_first", idx), bus.fa_c, v.sub | v.cin);
                check($sformatf("v%0d_fa_ab_first", idx), {bus.fa_a, bus.fa_b},
                      {v.a[0], v.b[0] ^ v.sub});
            end
            if (bus.busy) busy_n++;
            if (bus.done) begin
                got = 1;
                lat = i;
            end
        end
        check($sformatf("v%0d_latency", idx), lat, N + 1);
        check($sformatf("v%0d_busy_cycles", idx), busy_n, N);
        check($sformatf("v%0d_sum", idx), bus.sum, v.s);
        check($sformatf("v%0d_cout", idx), bus.cout, v.co);
        check($sformatf("v%0d_ovf", idx), bus.ovf, v.ov);
        check($sformatf("v%0d_fa_idle", idx), {bus.fa_a, bus.fa_b, bus.fa_c, bus.busy}, 0);
        @(negedge clk);
        check($sformatf("v%0d_done_drop", idx), bus.done, 0);
    endtask

    // Wait (bounded) until the block is back to idle
    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) ok = 1;
        end
        check(name, ok, 1);
    endtask

    initial begin
        int done_n;
        int first;
        int prev;
        logic [7:0] cap;

        vecs[0] = '{1'b0, 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'h03, 8'h01, 8'h02, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_status", {bus.busy, bus.done, bus.cout, bus.ovf}, 0);
        check("reset_sum", bus.sum, 0);
        check("reset_fa", {bus.fa_a, bus.fa_b, bus.fa_c}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {bus.busy, bus.done}, 0);

        for (int k = 0; k < 9; k++) do_op(vecs[k], k);

        // Second start during RUN is ignored
        @(negedge clk);
        bus.sub = 1'b0; bus.cin = 1'b0; bus.a = 8'h0F; bus.b = 8'h01; bus.start = 1'b1;
        @(posedge clk);
        done_n = 0; first = 0; cap = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4) begin
                bus.a = 8'h01; bus.b = 8'h00; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                done_n++;
                if (first == 0) begin
                    first = i;
                    cap   = bus.sum;
                end
            end
        end
        check("ign_done_count", done_n, 1);
        check("ign_done_time", first, N + 1);
        check("ign_sum", cap, 8'h10);

        // Back-to-back operations with start held high
        @(negedge clk);
        bus.sub = 1'b0; bus.cin = 1'b0; bus.a = 8'h01; bus.b = 8'h01; bus.start = 1'b1;
        @(posedge clk);
        done_n = 0; prev = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_n++;
                check($sformatf("b2b_sum_%0d", done_n), bus.sum, 8'h02);
                check($sformatf("b2b_busy_low_%0d", done_n), bus.busy, 0);
                if (prev != 0) check($sformatf("b2b_period_%0d", done_n), i - prev, N + 1);
                prev = i;
            end else if (prev != 0 && prev == i - 1) begin
                check($sformatf("b2b_busy_back_%0d", done_n), bus.busy, 1);
            end
        end
        check("b2b_done_count", done_n, 4);
        bus.start = 1'b0;
        drain("b2b_drain");

        // Reset in the middle of RUN
        @(negedge clk);
        bus.sub = 1'b0; bus.cin = 1'b0; bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 3) check("run_sum_stable", bus.sum, 8'h02);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_status", {bus.busy, bus.done, bus.cout, bus.ovf}, 0);
        check("midrst_sum", bus.sum, 0);
        check("midrst_fa", {bus.fa_a, bus.fa_b, bus.fa_c}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) done_n++;
        end
        check("midrst_stays_idle", done_n, 0);
        do_op(vecs[0], 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
